// File: rtl/uart_tx_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_engine
// Description : Parametrised UART transmitter with internal bit-period
//               divider, optional parity and 1/2 stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_engine #(
    parameter int DATA_BITS = 8,
    parameter int CLK_DIV   = 434,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Tx_Valid,
    input  logic [DATA_BITS-1:0] Tx_Data,
    output logic                 Tx_Ready,
    output logic                 Tx_Busy,
    output logic                 Tx_Done_Sig,
    output logic                 Tx_Pin_Out
);

    localparam int c_DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int c_CNT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_LAST = c_CNT_W'(STOP_BITS - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame_engine: DATA_BITS must be 5..9");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_frame_engine: CLK_DIV must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame_engine: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame_engine: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_DIV_W-1:0]   r_div;
    logic [c_DIV_W-1:0]   w_div_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic                 r_pin;
    logic                 w_pin_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_tick;
    logic                 w_par_calc;

    assign w_tick     = (r_div == c_DIV_LAST);
    // Odd parity inverts the XOR so the total count of ones comes out odd.
    assign w_par_calc = (PARITY == 1) ? ~(^Tx_Data) : (^Tx_Data);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_pin   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_pin   <= w_pin_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_pin_nxt   = r_pin;
        w_done_nxt  = 1'b0;

        if (r_state != S_IDLE) begin
            w_div_nxt = w_tick ? '0 : (r_div + c_DIV_W'(1));
        end

        case (r_state)
            S_IDLE: begin
                w_pin_nxt = 1'b1;
                // Start bit is driven on the acceptance edge itself.
                if (Tx_Valid) begin
                    w_shift_nxt = Tx_Data;
                    w_par_nxt   = w_par_calc;
                    w_pin_nxt   = 1'b0;
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                if (w_tick) begin
                    w_pin_nxt   = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    if (r_cnt == c_DATA_LAST) begin
                        w_cnt_nxt = '0;
                        if (PARITY != 0) begin
                            w_pin_nxt   = r_par;
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_pin_nxt   = 1'b1;
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_pin_nxt   = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (w_tick) begin
                    w_pin_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end
            end

            S_STOP: begin
                w_pin_nxt = 1'b1;
                if (w_tick) begin
                    if (r_cnt == c_STOP_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end

            default: begin
                w_pin_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign Tx_Ready    = (r_state == S_IDLE);
    assign Tx_Busy     = ~Tx_Ready;
    assign Tx_Done_Sig = r_done;
    assign Tx_Pin_Out  = r_pin;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame_engine
// Description : Scoreboard bench for uart_tx_frame_engine in four build
//               configurations (8N1, 8E1, 8O1, 7N2), all at CLK_DIV = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_engine;

    localparam int c_DIV = 4;

    typedef struct packed {
        logic [3:0]  idx;
        logic [4:0]  nbits;
        logic [15:0] bits;   // line levels, bit 0 = start bit
        logic        b2b;
        logic        abort;
    } exp_t;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic [3:0] r_valid = 4'h0;
    logic [7:0] r_data = 8'h00;
    wire  [3:0] w_ready;
    wire  [3:0] w_busy;
    wire  [3:0] w_done;
    wire  [3:0] w_pin;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 r_clk = ~r_clk;

    uart_tx_frame_engine #(.DATA_BITS(8), .CLK_DIV(c_DIV), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
        .CLK(r_clk), .RST(r_rst), .Tx_Valid(r_valid[0]), .Tx_Data(r_data),
        .Tx_Ready(w_ready[0]), .Tx_Busy(w_busy[0]), .Tx_Done_Sig(w_done[0]), .Tx_Pin_Out(w_pin[0]));
    uart_tx_frame_engine #(.DATA_BITS(8), .CLK_DIV(c_DIV), .PARITY(2), .STOP_BITS(1)) u_dut_8e1 (
        .CLK(r_clk), .RST(r_rst), .Tx_Valid(r_valid[1]), .Tx_Data(r_data),
        .Tx_Ready(w_ready[1]), .Tx_Busy(w_busy[1]), .Tx_Done_Sig(w_done[1]), .Tx_Pin_Out(w_pin[1]));
    uart_tx_frame_engine #(.DATA_BITS(8), .CLK_DIV(c_DIV), .PARITY(1), .STOP_BITS(1)) u_dut_8o1 (
        .CLK(r_clk), .RST(r_rst), .Tx_Valid(r_valid[2]), .Tx_Data(r_data),
        .Tx_Ready(w_ready[2]), .Tx_Busy(w_busy[2]), .Tx_Done_Sig(w_done[2]), .Tx_Pin_Out(w_pin[2]));
    uart_tx_frame_engine #(.DATA_BITS(7), .CLK_DIV(c_DIV), .PARITY(0), .STOP_BITS(2)) u_dut_7n2 (
        .CLK(r_clk), .RST(r_rst), .Tx_Valid(r_valid[3]), .Tx_Data(r_data[6:0]),
        .Tx_Ready(w_ready[3]), .Tx_Busy(w_busy[3]), .Tx_Done_Sig(w_done[3]), .Tx_Pin_Out(w_pin[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int idx, input int nbits, input logic [15:0] bits,
                            input logic b2b, input logic abort);
        exp_t e;
        e.idx   = 4'(idx);
        e.nbits = 5'(nbits);
        e.bits  = bits;
        e.b2b   = b2b;
        e.abort = abort;
        sb_q.push_back(e);
    endtask

    // Watches one instance's line; pops an expected frame whenever a start bit appears.
    task automatic monitor(input int idx);
        exp_t        it;
        logic [15:0] got;
        int          glitches;
        int          early_done;
        int          fr_len;
        int          bitpos;
        logic        aborted;
        logic        just_done;
        logic        was_done;
        just_done = 1'b0;
        forever begin
            @(negedge r_clk);
            was_done  = just_done;
            just_done = 1'b0;
            if (r_rst) continue;
            if (w_pin[idx] == 1'b1) begin
                check($sformatf("idle_flags[dut%0d]", idx),
                      {29'd0, w_done[idx], w_ready[idx], w_busy[idx]}, 32'b010);
                continue;
            end
            check($sformatf("start_flags[dut%0d]", idx), {30'd0, w_ready[idx], w_busy[idx]}, 32'b01);
            check($sformatf("sb_pending[dut%0d]", idx), 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() == 0) continue;
            it = sb_q.pop_front();
            check($sformatf("sb_route[dut%0d]", idx), 32'(it.idx), 32'(idx));
            if (it.b2b) check($sformatf("b2b_gap[dut%0d]", idx), 32'(was_done), 32'd1);

            got        = 16'h0000;
            glitches   = 0;
            early_done = 0;
            aborted    = 1'b0;
            fr_len     = int'(it.nbits) * c_DIV;
            for (int j = 0; j < fr_len; j++) begin
                if (j > 0) @(negedge r_clk);
                if (r_rst) begin
                    aborted = 1'b1;
                    break;
                end
                bitpos = j / c_DIV;
                if ((j % c_DIV) == (c_DIV / 2)) got[bitpos] = w_pin[idx];
                if (w_pin[idx] !== it.bits[bitpos]) glitches++;
                if (w_done[idx] !== 1'b0) early_done++;
            end

            if (aborted) begin
                check($sformatf("abort_expected[dut%0d]", idx), 32'(it.abort), 32'd1);
                @(negedge r_clk);
                check($sformatf("abort_outputs[dut%0d]", idx),
                      {28'd0, w_pin[idx], w_ready[idx], w_busy[idx], w_done[idx]}, 32'b1100);
            end else begin
                check($sformatf("no_abort[dut%0d]", idx), 32'(it.abort), 32'd0);
                check($sformatf("frame_bits[dut%0d]", idx), 32'(got), 32'(it.bits));
                check($sformatf("bit_timing[dut%0d]", idx), 32'(glitches), 32'd0);
                check($sformatf("early_done[dut%0d]", idx), 32'(early_done), 32'd0);
                @(negedge r_clk);
                check($sformatf("done_cycle[dut%0d]", idx),
                      {28'd0, w_pin[idx], w_done[idx], w_ready[idx], w_busy[idx]}, 32'b1110);
                just_done = 1'b1;
            end
        end
    endtask

    task automatic wait_ready(input int idx);
        int n;
        n = 0;
        while (w_ready[idx] !== 1'b1 && n < 500) begin
            @(posedge r_clk);
            #1;
            n++;
        end
        check($sformatf("ready_timeout[dut%0d]", idx), 32'(w_ready[idx]), 32'd1);
    endtask

    task automatic send(input int idx, input logic [7:0] data);
        wait_ready(idx);
        r_valid[idx] = 1'b1;
        r_data       = data;
        @(posedge r_clk);
        #1;
        r_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx);
        wait_ready(idx);
        repeat (2) @(posedge r_clk);
        #1;
    endtask

    initial begin
        repeat (20000) @(posedge r_clk);
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none

        repeat (3) @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        @(negedge r_clk);
        check("reset_pin",   32'(w_pin),   32'hF);
        check("reset_ready", 32'(w_ready), 32'hF);
        check("reset_busy",  32'(w_busy),  32'h0);
        check("reset_done",  32'(w_done),  32'h0);

        // Quiet line for 100 cycles; the monitors flag any activity.
        repeat (100) @(posedge r_clk);
        #1;

        // 0xA5 8N1: {stop, A5, start} = 0x34A
        push_exp(0, 10, 16'h034A, 1'b0, 1'b0);
        send(0, 8'hA5);
        wait_idle(0);

        // 0x07 even parity -> parity 1: {1, 1, 07, 0} = 0x60E
        push_exp(1, 11, 16'h060E, 1'b0, 1'b0);
        send(1, 8'h07);
        wait_idle(1);

        // 0x07 odd parity -> parity 0: {1, 0, 07, 0} = 0x40E
        push_exp(2, 11, 16'h040E, 1'b0, 1'b0);
        send(2, 8'h07);
        wait_idle(2);

        // 0x55 7N2: {11, 1010101, 0} = 0x3AA
        push_exp(3, 10, 16'h03AA, 1'b0, 1'b0);
        send(3, 8'h55);
        wait_idle(3);

        // Back-to-back 0x11 (0x222) then 0x22 (0x244) with Tx_Valid held high.
        push_exp(0, 10, 16'h0222, 1'b0, 1'b0);
        push_exp(0, 10, 16'h0244, 1'b1, 1'b0);
        wait_ready(0);
        r_valid[0] = 1'b1;
        r_data     = 8'h11;
        @(posedge r_clk);
        #1;
        r_data = 8'h22;
        wait_ready(0);
        @(posedge r_clk);
        #1;
        check("b2b_accept", 32'(w_ready[0]), 32'd0);
        r_data = 8'hFF;
        repeat (8) @(posedge r_clk);
        #1;
        r_valid[0] = 1'b0;
        r_data     = 8'h00;
        wait_idle(0);

        // Reset while data bit 2 is on the line.
        push_exp(0, 10, 16'h0000, 1'b0, 1'b1);
        send(0, 8'h96);
        repeat (13) @(posedge r_clk);
        #1;
        r_rst = 1'b1;
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        repeat (2) @(posedge r_clk);
        #1;

        // 0x3C after the abort: {1, 3C, 0} = 0x278
        push_exp(0, 10, 16'h0278, 1'b0, 1'b0);
        send(0, 8'h3C);
        wait_idle(0);

        repeat (5) @(posedge r_clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
